timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Shares a single interval counter between up to NUM_REQ requesters on the IR receiver board (IR frame timeout, LED blink, buzzer hold-off, and similar). Requesters each present a duration in clock cycles and hold a request line. The scheduler grants the counter round-robin, runs it for the requested duration, and returns a one-cycle done pulse to the winner. It replaces per-feature free-running timers with one arbitrated resource.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 32, counter / duration width in bits

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  level request per requester; held high until done or abort
- duration  input  NUM_REQ*CNT_W  packed durations; requester i uses bits [i*CNT_W +: CNT_W]; sampled only at grant
- grant  output  NUM_REQ  one-hot; high for the winner from grant through the DONE cycle
- done  output  NUM_REQ  one-hot, one-cycle pulse at expiry
- busy  output  1  high in RUN and DONE
- active_id  output  $clog2(NUM_REQ)  index of the current or last winner
- remaining  output  CNT_W  cycles left in the current run (0 outside RUN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req is high, pick a winner round-robin, starting the search at index ptr.
  - Latch D = max(duration[winner], 1); a duration of 0 is treated as 1.
  - Load remaining = D-1 and go to RUN.
- RUN:
  - grant[winner]=1.
  - If req[winner] is low, abort: go to IDLE, no done pulse, ptr = winner+1 (mod NUM_REQ).
  - Otherwise, if remaining==0, go to DONE; else decrement remaining.
- DONE:
  - done[winner]=1 and grant[winner]=1 for exactly one cycle.
  - ptr = winner+1 (mod NUM_REQ); next state is IDLE.
- Handshake:
  - A requester clears req on the edge that ends its DONE cycle, using a registered response to done.
  - If req is still high in the following IDLE cycle, that is a new request. It competes normally and has lowest priority behind the others.
- The duration bus for non-winning requesters is ignored. A duration change during RUN has no effect.
- Requests arriving during RUN or DONE wait; there is no preemption.
- Arithmetic: remaining is unsigned CNT_W bits and never wraps. Decrement happens only when remaining is nonzero.

## Timing
- Reset values: state=IDLE, ptr=0, grant=0, done=0, busy=0, active_id=0, remaining=0. Reset mid-run drops grant on the next cycle with no done pulse.
- req high in IDLE at cycle t:
  - grant and busy are high from cycle t+1.
  - remaining=D-1 at t+1.
  - done is high at cycle t+D+1.
  - grant falls at t+D+2.
- Grant-to-grant minimum spacing is D+2 cycles, because one IDLE cycle follows every DONE.
- Abort: req[winner] low at RUN cycle a; grant is low and the state is IDLE at a+1.
- Simultaneous requests in IDLE: the lowest index at or above ptr (cyclically) wins. Losers keep req high and are served in rotation.
- All outputs are registered; there is no combinational path from req or duration to any output.

## Structure
- Package timer_sched_pkg: state enum (IDLE, RUN, DONE), default NUM_REQ/CNT_W constants, and a 50 MHz cycle constant for common durations (CYC_0P5S = 25_000_000).
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req and ptr. Outputs a valid flag and the winner index.
- The top level holds the FSM, the latched winner, the counter and ptr.

## Test plan
- Single request: req[0]=1 with duration=5 -> grant[0] for cycles t+1..t+6, done[0] at t+6, remaining counts 4,3,2,1,0 at t+1..t+5, then IDLE at t+7.
- Zero duration: req[2]=1 with duration=0 -> behaves as D=1: done[2] at t+2, grant high for two cycles.
- Contention: req=4'b1111 held, all durations=3, ptr=0 after reset -> grant order 0,1,2,3,0, each done spaced 5 cycles apart.
- Abort: req[1] drops two cycles into a duration=10 run -> grant[1] falls the next cycle, no done, next grant goes to index 2 if it is requesting.
- Reset mid-run: reset asserted during RUN with remaining=7 -> all outputs 0 the next cycle, and ptr=0.
- Re-request: requester 3 alone keeps req high after done -> re-granted in the IDLE cycle following DONE, with the new duration sampled at that grant.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared state encoding and default sizing for the timer scheduler.
package timer_sched_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF = 32;
   localparam int CYC_0P5S = 25_000_000;
endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first requester at or after ptr wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               valid,
   output logic [IDW-1:0]     idx
);
   always_comb begin
      valid = |req;
      idx = '0;
      // Scan from farthest to nearest so the closest requester to ptr is assigned last.
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NUM_REQ]) idx = IDW'((int'(ptr) + i) % NUM_REQ);
   end
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: one interval counter shared round-robin between NUM_REQ requesters.
module timer_scheduler import timer_sched_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF,
   localparam int IDW = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] duration,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [IDW-1:0]           active_id,
   output logic [CNT_W-1:0]         remaining
);
   state_t state_q, state_d;
   logic [IDW-1:0] winner_q, winner_d, ptr_q, ptr_d, next_ptr, arb_idx;
   logic [CNT_W-1:0] remaining_q, remaining_d, dur_sel;
   logic arb_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req(req),
      .ptr(ptr_q),
      .valid(arb_valid),
      .idx(arb_idx)
   );

   assign dur_sel = duration[int'(arb_idx)*CNT_W +: CNT_W];
   assign next_ptr = (winner_q == IDW'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      winner_d = winner_q;
      ptr_d = ptr_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: if (arb_valid) begin
            winner_d = arb_idx;
            // A zero duration behaves as one cycle, so the load value saturates at 0.
            remaining_d = (dur_sel == '0) ? '0 : dur_sel - 1'b1;
            state_d = RUN;
         end
         RUN: if (!req[winner_q]) begin
            state_d = IDLE;
            remaining_d = '0;
            ptr_d = next_ptr;
         end else if (remaining_q == '0) state_d = DONE;
         else remaining_d = remaining_q - 1'b1;
         DONE: begin
            state_d = IDLE;
            ptr_d = next_ptr;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         winner_q <= '0;
         ptr_q <= '0;
         remaining_q <= '0;
      end else begin
         state_q <= state_d;
         winner_q <= winner_d;
         ptr_q <= ptr_d;
         remaining_q <= remaining_d;
      end
   end

   assign grant = (state_q != IDLE) ? NUM_REQ'(1) << winner_q : '0;
   assign done = (state_q == DONE) ? NUM_REQ'(1) << winner_q : '0;
   assign busy = state_q != IDLE;
   assign active_id = winner_q;
   assign remaining = remaining_q;
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: scoreboarded directed + random checks against a cycle-number reference model.
module tb_timer_scheduler;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 0, reset = 1;
   logic [N-1:0] req = '0;
   logic [N*W-1:0] duration = '0;
   logic [N-1:0] grant, done;
   logic busy;
   logic [$clog2(N)-1:0] active_id;
   logic [W-1:0] remaining;

   timer_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
      .clk(clk), .reset(reset), .req(req), .duration(duration),
      .grant(grant), .done(done), .busy(busy), .active_id(active_id), .remaining(remaining)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [N-1:0] g;
      logic [N-1:0] d;
      logic b;
      int id;
      logic [W-1:0] r;
   } exp_t;

   exp_t exp_q[$];
   exp_t me;
   int checks = 0, errors = 0, cyc = 0;
   int own = -1, st = 0, dd = 0, ptr = 0, last = 0;
   logic [N-1:0] keep = '0, pd = '0, cur_d = '0, prev_g = '0;
   int gorder[$];

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
      end
   endtask

   // Reference: a grant issued at cycle st with length dd occupies cycles st..st+dd, done on st+dd.
   task automatic model();
      exp_t e;
      int dv;
      if (reset) begin
         own = -1; ptr = 0; last = 0;
      end else if (own >= 0) begin
         if (cyc - 1 == st + dd || !req[own]) begin
            ptr = (own + 1) % N; own = -1;
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) if (req[(ptr + k) % N]) own = (ptr + k) % N;
         if (own >= 0) begin
            dv = int'(duration[own*W +: W]);
            st = cyc; dd = (dv == 0) ? 1 : dv; last = own;
         end
      end
      e.g = (own >= 0) ? N'(1) << own : '0;
      e.d = (own >= 0 && cyc == st + dd) ? e.g : '0;
      e.b = own >= 0;
      e.id = last;
      e.r = (own >= 0 && cyc < st + dd) ? W'(st + dd - 1 - cyc) : '0;
      cur_d = e.d;
      exp_q.push_back(e);
   endtask

   task automatic step(bit rnd);
      @(posedge clk);
      cyc++;
      model();
      #1;
      if (rnd) keep = N'($urandom);
      for (int i = 0; i < N; i++) begin
         if (pd[i] && !keep[i]) req[i] = 1'b0;
         if (rnd) begin
            if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
            else if (req[i] && !pd[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
            duration[i*W +: W] = W'($urandom_range(0, 12));
         end
      end
      pd = cur_d;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   always @(negedge clk) if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk("grant", 64'(grant), 64'(me.g));
      chk("done", 64'(done), 64'(me.d));
      chk("busy", 64'(busy), 64'(me.b));
      chk("active_id", 64'(active_id), 64'(me.id));
      chk("remaining", 64'(remaining), 64'(me.r));
      if (grant != '0 && prev_g == '0)
         for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
      prev_g = grant;
   end

   initial begin
      steps(3);
      reset = 0;
      steps(2);
      // single request, duration 5
      req[0] = 1; duration[0*W +: W] = 5;
      steps(10);
      // zero duration treated as one
      req[2] = 1; duration[2*W +: W] = 0;
      steps(5);
      // contention with all requesters held high
      reset = 1; step(1'b0); reset = 0;
      for (int i = 0; i < N; i++) duration[i*W +: W] = 3;
      gorder.delete();
      req = '1; keep = '1;
      steps(24);
      if (gorder.size() < 5) chk("order_len", 64'(gorder.size()), 64'd5);
      else for (int k = 0; k < 5; k++) chk("order", 64'(gorder[k]), 64'(k % N));
      req = '0; keep = '0;
      steps(4);
      // abort two cycles into a long run, then 2 beats 0 via the rotated pointer
      req[1] = 1; duration[1*W +: W] = 10;
      steps(2);
      req[1] = 0; req[0] = 1; req[2] = 1;
      duration[0*W +: W] = 2; duration[2*W +: W] = 4;
      steps(20);
      // reset while remaining is 7
      req = 4'b0010; duration[1*W +: W] = 10;
      steps(3);
      req = 4'b0111; reset = 1;
      step(1'b0);
      reset = 0;
      steps(30);
      req = '0;
      steps(3);
      // re-request from requester 3 with a new duration sampled at the second grant
      req[3] = 1; keep[3] = 1; duration[3*W +: W] = 4;
      steps(3);
      duration[3*W +: W] = 2;
      steps(10);
      keep = '0;
      steps(6);
      req = '0;
      steps(2);
      // randomized traffic
      for (int i = 0; i < 3000; i++) step(1'b1);
      req = '0; keep = '0;
      steps(20);
      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
